masked_sbox_addr_ctrl: RTL and testbench



---
 rtl/masked_sbox_addr_ctrl_pkg.sv | 15 +
 rtl/masked_sbox_addr_ctrl_if.sv | 27 ++
 rtl/masked_sbox_addr_ctrl_lat_valid_pipe.sv | 27 ++
 rtl/masked_sbox_addr_ctrl.sv | 66 ++++++
 tb/tb_masked_sbox_addr_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/masked_sbox_addr_ctrl_pkg.sv
// masked_sbox_pkg: shared constants and FSM state type for the masked S-box feeder
// Build option: MASKED_SBOX_ADDR_REG_EN registers the BRAM addresses (one extra cycle of latency).
package masked_sbox_pkg;
    localparam int BRAM_LAT      = 2;
    localparam int RND_W         = 2;
    localparam int ADDR_W        = 10;
    localparam int BYTES_PER_BLK = 16;
    localparam int CNT_W         = $clog2(BYTES_PER_BLK);
`ifdef MASKED_SBOX_ADDR_REG_EN
    localparam int PIPE_D        = BRAM_LAT + 1;
`else
    localparam int PIPE_D        = BRAM_LAT;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/masked_sbox_addr_ctrl_if.sv
// masked_sbox_addr_ctrl_if: share-pair input, BRAM port and result handshake bundle
// slave  (the block): takes in_valid/share0/share1/rnd_in/out_ready, drives the rest.
// master (feeder/consumer): the mirror image.
interface masked_sbox_addr_ctrl_if;
    import masked_sbox_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        share0;
    logic [7:0]        share1;
    logic [RND_W-1:0]  rnd_in;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              bram_en;
    logic              bram_rst;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    modport slave (
        input  in_valid, share0, share1, rnd_in, out_ready,
        output in_ready, addr_a, addr_b, bram_en, bram_rst, out_valid, out_last, busy
    );
    modport master (
        output in_valid, share0, share1, rnd_in, out_ready,
        input  in_ready, addr_a, addr_b, bram_en, bram_rst, out_valid, out_last, busy
    );
endinterface

// File: rtl/masked_sbox_addr_ctrl_lat_valid_pipe.sv
// lat_valid_pipe: DEPTH-stage {valid, last} shift register that advances only when en is high
// Ports: clk, rst (sync, active-high), en, in_valid/in_last in, out_valid/out_last from the final stage.
// DEPTH must be at least 2.
module lat_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);
    logic [DEPTH-1:0] v, l;
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            l <= '0;
        end else if (en) begin
            v <= {v[DEPTH-2:0], in_valid};
            l <= {l[DEPTH-2:0], in_last};
        end
    end
    assign out_valid = v[DEPTH-1];
    assign out_last  = l[DEPTH-1];
endmodule

// File: rtl/masked_sbox_addr_ctrl.sv
// masked_sbox_addr_ctrl: forms masked S-box BRAM addresses per share pair and tracks BRAM read latency
// Ports: clk, rst (sync, active-high, also forwarded as bram_rst), bus (masked_sbox_addr_ctrl_if.slave).
// Build option: MASKED_SBOX_ADDR_REG_EN registers addr_a/addr_b on accept (latency BRAM_LAT+1).
module masked_sbox_addr_ctrl
    import masked_sbox_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    masked_sbox_addr_ctrl_if.slave bus
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RND_W-1:0] rnd_q;
    logic             adv, acc, last_in;
    // A result sitting at the output that is not consumed freezes the whole BRAM pipe.
    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.bram_en  = (state != IDLE) && adv;
    assign bus.in_ready = bus.bram_en && (state == RUN);
    assign bus.bram_rst = rst;
    assign bus.busy     = state != IDLE;
    assign acc          = bus.in_ready && bus.in_valid;
    assign last_in      = acc && (cnt == CNT_W'(BYTES_PER_BLK - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rnd_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    rnd_q <= bus.rnd_in;
                    state <= RUN;
                end
                RUN: if (acc) begin
                    cnt <= last_in ? '0 : cnt + 1'b1;
                    if (last_in) state <= DRAIN;
                end
                DRAIN: if (bus.out_valid && bus.out_ready && bus.out_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MASKED_SBOX_ADDR_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.addr_a <= '0;
            bus.addr_b <= '0;
        end else if (acc) begin
            bus.addr_a <= {rnd_q, bus.share0};
            bus.addr_b <= {rnd_q, bus.share1};
        end
    end
`else
    assign bus.addr_a = acc ? {rnd_q, bus.share0} : '0;
    assign bus.addr_b = acc ? {rnd_q, bus.share1} : '0;
`endif
    lat_valid_pipe #(.DEPTH(PIPE_D)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.bram_en),
        .in_valid  (acc),
        .in_last   (last_in),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last)
    );
endmodule

// File: tb/tb_masked_sbox_addr_ctrl.sv
// tb_masked_sbox_addr_ctrl: directed bench with an identity-content two-port BRAM model (DOA_REG=1)
module tb_masked_sbox_addr_ctrl;
`ifdef MASKED_SBOX_ADDR_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int failures = 0;
    logic [9:0] lat_a, lat_b, doa, dob, doa_p3;
    masked_sbox_addr_ctrl_if bus();
    masked_sbox_addr_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // BRAM whose content at address x is x: array latch then output register, both gated by EN/REGCE.
    always @(posedge clk) begin
        if (bus.bram_rst) begin
            lat_a <= '0; lat_b <= '0; doa <= '0; dob <= '0;
        end else if (bus.bram_en) begin
            lat_a <= bus.addr_a; lat_b <= bus.addr_b;
            doa <= lat_a; dob <= lat_b;
        end
    end
    task automatic run_block(input string nm, input logic [1:0] rnd, input int stall_at,
                             input int stall_len, input bit bubbles, input int abort_after);
        int p = 0, r = 0, n_last = 0, first_acc = -1, first_out = -1;
        bit tog = 1, done = 0, stalled, prev_stalled = 0;
        bit acc_hist[256];
        logic [9:0] prev_doa = '0, prev_dob = '0;
        logic prev_ov = 0;
        @(posedge clk); #1;
        bus.rnd_in = rnd; bus.out_ready = 1; bus.in_valid = 1; bus.share0 = 8'h00; bus.share1 = 8'hff;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            stalled = !bus.out_ready;
            acc_hist[cyc] = bus.in_valid && bus.in_ready;
            if (stall_len == 0 && cyc >= LAT) begin
                checks++;
                if (bus.out_valid !== acc_hist[cyc-LAT]) begin
                    failures++;
                    $display("FAIL %s valid_pattern cyc=%0d got=%b exp=%b", nm, cyc, bus.out_valid, acc_hist[cyc-LAT]);
                end
            end
            if (stalled && bus.out_valid) begin
                checks++;
                if (bus.bram_en !== 1'b0 || bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stall_gate cyc=%0d got en=%b rdy=%b exp 0 0", nm, cyc, bus.bram_en, bus.in_ready);
                end
            end
            if (stalled && prev_stalled) begin
                checks++;
                if (doa !== prev_doa || dob !== prev_dob || bus.out_valid !== prev_ov) begin
                    failures++;
                    $display("FAIL %s stall_hold cyc=%0d got %h/%h/%b exp %h/%h/%b", nm, cyc, doa, dob, bus.out_valid, prev_doa, prev_dob, prev_ov);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (first_out < 0) first_out = cyc;
                if (r == 3) doa_p3 = doa;
                checks++;
                if (doa !== {rnd, r[7:0]} || dob !== {rnd, ~r[7:0]} || bus.out_last !== (r == 15)) begin
                    failures++;
                    $display("FAIL %s result%0d got a=%h b=%h last=%b exp a=%h b=%h last=%b", nm, r, doa, dob, bus.out_last, {rnd, r[7:0]}, {rnd, ~r[7:0]}, r == 15);
                end
                n_last += int'(bus.out_last);
                r++;
            end
            if (acc_hist[cyc]) begin
                if (first_acc < 0) first_acc = cyc;
                p++;
            end
            prev_stalled = stalled; prev_doa = doa; prev_dob = dob; prev_ov = bus.out_valid;
            if ((abort_after > 0 && p == abort_after) || (r == 16 && !bus.busy)) done = 1;
            else begin
                @(posedge clk); #1;
                bus.out_ready = !(cyc + 1 >= stall_at && cyc + 1 < stall_at + stall_len);
                tog = !tog;
                bus.in_valid = p < 16 && (!bubbles || tog);
                bus.share0 = p[7:0];
                bus.share1 = ~p[7:0];
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout got results=%0d accepts=%0d exp completion", nm, r, p);
        end
        if (abort_after == 0) begin
            checks++;
            if (r != 16 || p != 16 || n_last != 1) begin
                failures++;
                $display("FAIL %s counts got res=%0d acc=%0d last=%0d exp 16 16 1", nm, r, p, n_last);
            end
            checks++;
            if (first_out - first_acc != LAT) begin
                failures++;
                $display("FAIL %s first_latency got=%0d exp=%0d", nm, first_out - first_acc, LAT);
            end
        end
        bus.in_valid = 0;
    endtask
    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (bus.bram_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_bram_rst got=%b exp=1", bus.bram_rst);
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.bram_en, bus.out_valid, bus.out_last, bus.busy, bus.bram_rst} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b en=%b ov=%b ol=%b busy=%b brst=%b exp all 0", bus.in_ready, bus.bram_en, bus.out_valid, bus.out_last, bus.busy, bus.bram_rst);
        end
        checks++;
        if (bus.addr_a !== 10'h0 || bus.addr_b !== 10'h0) begin
            failures++;
            $display("FAIL reset_addr got a=%h b=%h exp 0 0", bus.addr_a, bus.addr_b);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.bram_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got busy=%b en=%b exp 0 0", bus.busy, bus.bram_en);
        end
    endtask
    task automatic test_stream;
        run_block("stream", 2'b10, 0, 0, 0, 0);
        checks++;
        if (doa_p3 !== 10'h203) begin
            failures++;
            $display("FAIL stream_pair3_addr got=%h exp=203", doa_p3);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got busy=%b ov=%b exp 0 0", bus.busy, bus.out_valid);
        end
    endtask
    task automatic test_backpressure;
        run_block("backpressure", 2'b11, 8, 5, 0, 0);
    endtask
    task automatic test_bubbles;
        run_block("bubbles", 2'b00, 0, 0, 1, 0);
    endtask
    task automatic test_reset_mid;
        run_block("mid_abort", 2'b10, 0, 0, 0, 7);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ctrl got ov=%b busy=%b rdy=%b exp 0 0 0", bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++;
        if (doa !== 10'h0 || dob !== 10'h0) begin
            failures++;
            $display("FAIL mid_reset_bram got a=%h b=%h exp 0 0", doa, dob);
        end
        run_block("after_reset", 2'b01, 0, 0, 0, 0);
    endtask
    initial begin
        bus.in_valid = 0; bus.out_ready = 1; bus.share0 = 0; bus.share1 = 0; bus.rnd_in = 0;
        test_reset;
        test_stream;
        test_backpressure;
        test_bubbles;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
